// File: rtl/sm_trace_buffer_pkg.sv
// sm_trace_buffer_pkg: capture state encodings and trace entry word indices
package sm_trace_buffer_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
    localparam int W_CYCLE = 0;
    localparam int W_PC    = 1;
    localparam int W_INSTR = 2;
    localparam int W_CH0   = 3;
endpackage

// File: rtl/sm_trace_buffer_ram.sv
// sm_trace_buffer_ram: simple dual-port entry RAM, one write port, one registered read port
module sm_trace_buffer_ram #(
    parameter int DEPTH = 64,
    parameter int DW    = 160
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DW-1:0]            i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DW-1:0]            o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];
    // write whole entries; read returns the pre-write contents on an address collision
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/sm_trace_buffer.sv
// sm_trace_buffer: circular instruction-trace capture with trigger, post window, timeout and readout
module sm_trace_buffer
    import sm_trace_buffer_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int NCH     = 2,
    parameter int TIMEOUT = 120
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_sample_en,
    input  logic [31:0]              i_pc,
    input  logic [31:0]              i_instr,
    input  logic [32*NCH-1:0]        i_ch_data,
    input  logic                     i_arm,
    input  logic                     i_stop,
    input  logic [31:0]              i_trig_val,
    input  logic [31:0]              i_trig_mask,
    input  logic [$clog2(DEPTH)-1:0] i_post_cnt,
    input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
    input  logic [3:0]               i_rd_word,
    output logic [31:0]              o_rd_data,
    output logic [1:0]               o_state,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_trig_hit,
    output logic                     o_timed_out
);
    localparam int AW    = $clog2(DEPTH);
    localparam int WORDS = W_CH0 + NCH;
    localparam int DW    = 32 * WORDS;

    state_t        r_state, w_next;
    logic [AW-1:0] r_wr_ptr, r_rem, w_raddr;
    logic [AW:0]   r_count;
    logic [31:0]   r_samp;
    logic          r_trig, r_tmo, r_rd_valid;
    logic [3:0]    r_rd_word;
    logic [DW-1:0] w_ram_q, w_shift;
    logic          w_active, w_we, w_match, w_tmo_hit, w_restart, w_valid;

    assign w_active  = r_state == ST_ARMED || r_state == ST_POST;
    assign w_we      = w_active && i_sample_en && !i_stop;
    assign w_match   = ((i_instr ^ i_trig_val) & i_trig_mask) == '0;
    assign w_tmo_hit = TIMEOUT != 0 && r_samp == 32'(TIMEOUT - 1);
    assign w_restart = !w_active && i_arm;
    // oldest entry sits count slots behind the write pointer
    assign w_raddr   = r_wr_ptr - r_count[AW-1:0] + i_rd_idx;
    assign w_valid   = {1'b0, i_rd_idx} < r_count && i_rd_word < 4'(WORDS);
    assign w_shift   = w_ram_q >> {r_rd_word, 5'b0};

    assign o_rd_data   = r_rd_valid ? w_shift[31:0] : '0;
    assign o_state     = r_state;
    assign o_count     = r_count;
    assign o_trig_hit  = r_trig;
    assign o_timed_out = r_tmo;

    sm_trace_buffer_ram #(.DEPTH(DEPTH), .DW(DW)) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata ({i_ch_data, i_instr, i_pc, r_samp}),
        .i_raddr (w_raddr),
        .o_rdata (w_ram_q)
    );

    // next capture state; trigger takes priority over timeout on the same sample
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_ARMED: begin
                if (i_stop) w_next = ST_DONE;
                else if (i_sample_en && w_match) w_next = i_post_cnt == '0 ? ST_DONE : ST_POST;
                else if (i_sample_en && w_tmo_hit) w_next = ST_DONE;
            end
            ST_POST: if (i_stop || (i_sample_en && r_rem == AW'(1))) w_next = ST_DONE;
            default: if (i_arm) w_next = ST_ARMED;
        endcase
    end

    // state register, write pointer, fill count, sample counter and end-cause flags
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_samp   <= '0;
            r_rem    <= '0;
            r_trig   <= 1'b0;
            r_tmo    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_restart) begin
                r_wr_ptr <= '0;
                r_count  <= '0;
                r_samp   <= '0;
                r_trig   <= 1'b0;
                r_tmo    <= 1'b0;
            end else if (w_we) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_count  <= r_count == (AW+1)'(DEPTH) ? r_count : r_count + 1'b1;
                r_samp   <= r_samp + 32'd1;
                r_rem    <= r_state == ST_ARMED ? i_post_cnt : r_rem - 1'b1;
                if (r_state == ST_ARMED && w_match) r_trig <= 1'b1;
                else if (r_state == ST_ARMED && w_tmo_hit) r_tmo <= 1'b1;
            end
        end
    end

    // readout qualifier and word select travel alongside the RAM read
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_word  <= '0;
        end else begin
            r_rd_valid <= w_valid;
            r_rd_word  <= i_rd_word;
        end
    end
endmodule

// File: tb/tb_sm_trace_buffer.sv
// tb_sm_trace_buffer: scoreboard bench against a queue-based capture model
module tb_sm_trace_buffer;
    localparam int DEPTH   = 8;
    localparam int NCH     = 2;
    localparam int TIMEOUT = 12;
    localparam int AW      = 3;
    localparam logic [31:0] TV = 32'h1000FFFF;

    typedef struct packed {
        logic [31:0] c1, c0, ins, pc, n;
    } ent_t;

    logic          clk = 1'b0;
    logic          i_rst_n, i_sample_en, i_arm, i_stop;
    logic [31:0]   i_pc, i_instr, i_trig_val, i_trig_mask;
    logic [63:0]   i_ch_data;
    logic [AW-1:0] i_post_cnt, i_rd_idx;
    logic [3:0]    i_rd_word;
    logic [31:0]   o_rd_data;
    logic [1:0]    o_state;
    logic [AW:0]   o_count;
    logic          o_trig_hit, o_timed_out;

    int   total = 0, bad = 0;
    int   ms = 0, samp = 0, rem = 0;
    bit   mtrig = 0, mtmo = 0, rd_v = 0;
    ent_t hist[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    sm_trace_buffer #(.DEPTH(DEPTH), .NCH(NCH), .TIMEOUT(TIMEOUT)) dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_sample_en (i_sample_en),
        .i_pc        (i_pc),
        .i_instr     (i_instr),
        .i_ch_data   (i_ch_data),
        .i_arm       (i_arm),
        .i_stop      (i_stop),
        .i_trig_val  (i_trig_val),
        .i_trig_mask (i_trig_mask),
        .i_post_cnt  (i_post_cnt),
        .i_rd_idx    (i_rd_idx),
        .i_rd_word   (i_rd_word),
        .o_rd_data   (o_rd_data),
        .o_state     (o_state),
        .o_count     (o_count),
        .o_trig_hit  (o_trig_hit),
        .o_timed_out (o_timed_out)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(ent_t e, int w);
        case (w)
            0: return e.n;
            1: return e.pc;
            2: return e.ins;
            3: return e.c0;
            4: return e.c1;
            default: return 32'h0;
        endcase
    endfunction

    // capture model: history is a bounded queue, oldest at the front
    task automatic model_edge();
        ent_t e;
        if (!i_rst_n) begin
            ms = 0; samp = 0; rem = 0; mtrig = 0; mtmo = 0;
            hist.delete();
        end else if (ms == 0 || ms == 3) begin
            if (i_arm) begin
                ms = 1; samp = 0; mtrig = 0; mtmo = 0;
                hist.delete();
            end
        end else if (i_stop) begin
            ms = 3;
        end else if (i_sample_en) begin
            e.n = samp; e.pc = i_pc; e.ins = i_instr; e.c0 = i_ch_data[31:0]; e.c1 = i_ch_data[63:32];
            if (hist.size() == DEPTH) void'(hist.pop_front());
            hist.push_back(e);
            if (ms == 1) begin
                if (((i_instr ^ i_trig_val) & i_trig_mask) == 32'h0) begin
                    mtrig = 1;
                    rem = int'(i_post_cnt);
                    ms = rem == 0 ? 3 : 2;
                end else if (TIMEOUT != 0 && samp == TIMEOUT - 1) begin
                    mtmo = 1;
                    ms = 3;
                end
            end else begin
                rem--;
                if (rem == 0) ms = 3;
            end
            samp++;
        end
    endtask

    // one clock: queue the expected readout, advance the model, compare status
    task automatic tick();
        int idx;
        idx = int'(i_rd_idx);
        if (i_rst_n && idx < hist.size()) exp_q.push_back(word_of(hist[idx], int'(i_rd_word)));
        else exp_q.push_back(32'h0);
        model_edge();
        @(posedge clk);
        #1;
        chk("state", 32'(o_state), 32'(ms));
        chk("count", 32'(o_count), 32'(hist.size()));
        chk("trig_hit", 32'(o_trig_hit), 32'(mtrig));
        chk("timed_out", 32'(o_timed_out), 32'(mtmo));
    endtask

    always @(posedge clk) rd_v <= 1'b1;

    // monitor: every registered readout is matched against the oldest queued expectation
    always @(negedge clk) begin
        if (rd_v) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL rd_queue: got empty queue expected pending entry");
            end else chk("rd_data", o_rd_data, exp_q.pop_front());
        end
    end

    function automatic logic [31:0] nm();
        logic [31:0] v;
        v = $urandom;
        return v == TV ? ~v : v;
    endfunction

    task automatic smp(bit en, logic [31:0] ins);
        i_sample_en = en;
        i_instr = ins;
        i_pc = $urandom;
        i_ch_data = {$urandom, $urandom};
        i_rd_idx = AW'($urandom);
        i_rd_word = 4'($urandom);
        tick();
        i_sample_en = 0;
    endtask

    task automatic rd(int idx, int w);
        i_rd_idx = AW'(idx);
        i_rd_word = 4'(w);
        tick();
    endtask

    task automatic arm_pulse();
        i_arm = 1;
        tick();
        i_arm = 0;
    endtask

    task automatic gap();
        if ($urandom_range(0, 2) == 0) smp(0, TV);
    endtask

    task automatic setup(logic [31:0] v, logic [31:0] m, int p);
        i_trig_val = v;
        i_trig_mask = m;
        i_post_cnt = AW'(p);
    endtask

    initial begin
        i_rst_n = 0; i_sample_en = 0; i_arm = 0; i_stop = 0;
        i_pc = 0; i_instr = 0; i_ch_data = 0; i_trig_val = 0; i_trig_mask = 0;
        i_post_cnt = 0; i_rd_idx = 0; i_rd_word = 0;
        tick();
        tick();
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        i_rst_n = 1;
        // trigger at sample 6 with a 3-sample post window wraps the 8-entry buffer
        setup(TV, 32'hFFFF_FFFF, 3);
        arm_pulse();
        for (int s = 0; s < 10; s++) begin
            gap();
            smp(1, s == 6 ? TV : nm());
        end
        chk("A_state", 32'(o_state), 32'd3);
        chk("A_count", 32'(o_count), 32'd8);
        chk("A_trig", 32'(o_trig_hit), 32'd1);
        for (int i = 0; i < 8; i++)
            for (int w = 0; w < 8; w++) rd(i, w);
        rd(4, 2);
        // timeout after 12 samples with no trigger
        arm_pulse();
        for (int s = 0; s < 11; s++) begin
            gap();
            smp(1, nm());
        end
        chk("B_armed", 32'(o_state), 32'd1);
        smp(1, nm());
        chk("B_state", 32'(o_state), 32'd3);
        chk("B_tmo", 32'(o_timed_out), 32'd1);
        chk("B_trig", 32'(o_trig_hit), 32'd0);
        rd(7, 0);
        rd(0, 0);
        // trigger on the timeout sample wins
        setup(TV, 32'hFFFF_FFFF, 0);
        arm_pulse();
        for (int s = 0; s < 11; s++) smp(1, nm());
        smp(1, TV);
        chk("C_state", 32'(o_state), 32'd3);
        chk("C_trig", 32'(o_trig_hit), 32'd1);
        chk("C_tmo", 32'(o_timed_out), 32'd0);
        // alternating sample enable
        arm_pulse();
        for (int s = 0; s < 4; s++) begin
            smp(1, nm());
            smp(0, TV);
        end
        chk("D_count", 32'(o_count), 32'd4);
        for (int i = 0; i < 4; i++) rd(i, 0);
        i_stop = 1;
        tick();
        i_stop = 0;
        chk("D_stop", 32'(o_state), 32'd3);
        // stop in POST suppresses the write, then arm with stop restarts
        setup(TV, 32'hFFFF_FFFF, 5);
        arm_pulse();
        for (int s = 0; s < 3; s++) smp(1, nm());
        smp(1, TV);
        smp(1, nm());
        chk("E_post", 32'(o_state), 32'd2);
        i_stop = 1;
        smp(1, nm());
        i_stop = 0;
        chk("E_done", 32'(o_state), 32'd3);
        chk("E_count", 32'(o_count), 32'd5);
        i_arm = 1; i_stop = 1;
        tick();
        i_arm = 0; i_stop = 0;
        chk("E_rearm", 32'(o_state), 32'd1);
        chk("E_count0", 32'(o_count), 32'd0);
        smp(1, nm());
        smp(1, nm());
        rd(5, 0);
        rd(1, 7);
        rd(1, 4);
        rd(1, 5);
        // reset during POST
        setup(TV, 32'hFFFF_FFFF, 6);
        arm_pulse();
        smp(1, nm());
        smp(1, TV);
        smp(1, nm());
        chk("F_post", 32'(o_state), 32'd2);
        i_rst_n = 0;
        tick();
        i_rst_n = 1;
        chk("F_state", 32'(o_state), 32'd0);
        chk("F_count", 32'(o_count), 32'd0);
        rd(0, 0);
        rd(3, 1);
        // random captures with sparse trigger masks, stray arm/stop and occasional reset
        for (int it = 0; it < 40; it++) begin
            setup($urandom, $urandom & $urandom & $urandom, $urandom_range(0, 7));
            arm_pulse();
            for (int c = 0; c < 30; c++) begin
                i_stop = $urandom_range(0, 39) == 0;
                i_arm = $urandom_range(0, 19) == 0;
                i_rst_n = $urandom_range(0, 199) != 0;
                smp($urandom_range(0, 3) != 0, $urandom);
                i_stop = 0; i_arm = 0; i_rst_n = 1;
            end
        end
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sm_trace_buffer.md
# sm_trace_buffer

Synthesizable instruction-trace capture unit for the single-cycle MIPS core, sitting beside `sm_cpu` inside `sm_top`. Each enabled CPU cycle it records a trace entry into a circular buffer: cycle number, PC, instruction word and NCH watched register values. Capture stops on a programmable instruction-match trigger after a post-trigger window, or on a cycle timeout. The captured history can then be read back word by word. It replaces print-based cycle tracing with on-chip capture that also works on the board.

## Interface
Parameters:
- DEPTH, 64, entries in buffer; power of two, ≥ 4
- NCH, 2, watched register channels, 1..8
- TIMEOUT, 120, samples after arm before forced stop; 0 disables timeout

Ports:
- clk  in  1  system clock, the same clock as the CPU
- rst_n  in  1  synchronous, active-low reset
- sample_en  in  1  CPU advanced this cycle; an entry is written only when this is 1
- pc  in  32  current PC (word address)
- instr  in  32  current instruction
- ch_data  in  32*NCH  watched registers; channel k is bits [32k+31:32k]
- arm  in  1  one-cycle pulse that starts a capture
- stop  in  1  forces DONE from ARMED/POST
- trig_val  in  32  trigger compare value
- trig_mask  in  32  trigger bit mask (1 = compare bit)
- post_cnt  in  log2(DEPTH)  samples stored after the trigger sample
- rd_idx  in  log2(DEPTH)  entry index, 0 = oldest
- rd_word  in  4  word within entry
- rd_data  out  32  readout word, registered
- state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
- count  out  log2(DEPTH)+1  valid entries, saturating at DEPTH
- trig_hit  out  1  capture ended by trigger
- timed_out  out  1  capture ended by timeout

## Operation
- Entry words: 0 = sample number since arm (32 bit, starting at 0); 1 = pc; 2 = instr; 3+k = channel k. WORDS = 3+NCH.
- IDLE: no writes. `arm` moves to ARMED and clears the write pointer, count, sample counter, trig_hit and timed_out.
- ARMED: every sample_en cycle writes an entry at wr_ptr. wr_ptr advances modulo DEPTH. count increments and saturates at DEPTH, so the oldest entry is overwritten. The sample counter increments.
- Trigger condition: sample_en & ((instr ^ trig_val) & trig_mask) == 0. The trigger sample itself is stored. trig_hit is set. If post_cnt = 0 the next state is DONE, otherwise POST, with the remaining count loaded from post_cnt.
- POST: each stored sample decrements the remaining count. The sample that brings it to 0 moves the block to DONE. post_cnt ≥ DEPTH-1 is clamped to DEPTH-1 so the trigger entry survives.
- Timeout applies in ARMED only. When the stored sample number equals TIMEOUT-1, the sample is stored, the block moves to DONE and timed_out is set. If the trigger and timeout hit on the same sample, the trigger wins: the block goes to POST or DONE with trig_hit set and timed_out left at 0.
- `stop` in ARMED or POST moves to DONE next cycle. No entry is written that cycle even if sample_en is 1.
- DONE: no writes. `arm` restarts the capture as from IDLE.
- `arm` while in ARMED or POST is ignored. `arm` and `stop` together in IDLE or DONE: arm wins.
- Readout is valid in any state but coherent only in DONE. Physical address = (wr_ptr − count + rd_idx) mod DEPTH. If rd_idx ≥ count or rd_word ≥ WORDS, rd_data = 0.

## Timing
- Reset: state = IDLE, count = 0, trig_hit = 0, timed_out = 0, rd_data = 0, pointers and counters = 0. RAM contents are not reset.
- Writes happen at the clk edge where sample_en = 1 and the state is ARMED or POST.
- state, count and the flags are registered and updated at the same edge as the write.
- rd_data has a 1-cycle latency from rd_idx/rd_word.
- Reset asserted mid-capture aborts it: state IDLE next edge, and later readout returns 0 because count = 0.

## Structure
- Shared header `sm_trace.vh`: state encodings (ST_IDLE..ST_DONE) and word indices (W_CYCLE, W_PC, W_INSTR, W_CH0).
- One sub-module, `sm_trace_ram`: simple dual-port RAM, DEPTH × (32·WORDS), one write port and one synchronous read port, no reset. The word select mux stays in the top level.

## Test plan
- DEPTH=8, TIMEOUT=0, trigger on instr 32'h1000FFFF with mask all-ones at sample 20, post_cnt=3. Required: DONE after sample 23; count = 8; entries hold samples 16..23; rd_idx 4 word 2 = 32'h1000FFFF; trig_hit = 1.
- No trigger, TIMEOUT=12, DEPTH=64. Required: DONE after 12 samples; count = 12; timed_out = 1; entry 11 word 0 = 11.
- Trigger and timeout on the same sample (TIMEOUT=5, trigger at sample 4, post_cnt=0). Required: DONE, trig_hit = 1, timed_out = 0.
- sample_en toggling 1,0,1,0 in ARMED. Required: only the enabled cycles are stored, and word 0 values are consecutive.
- `stop` during POST, then `arm` in DONE. Required: DONE with no extra entry, then ARMED with count = 0. rd_idx ≥ count and rd_word = 7 with NCH=2 both read as 0.
- rst_n low for 1 cycle during POST. Required: state = 0, count = 0, rd_data = 0 on the next read.
